// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master sequencer: frame command codes,
// frame geometry and the controller state encoding.
package spi_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int         FRAME_BITS = 10;
  localparam int         RX_BITS    = 8;
  localparam logic [7:0] DUMMY_BYTE = 8'hFF;

  localparam logic [3:0] SHIFT_LAST = 4'(FRAME_BITS - 1);
  localparam logic [3:0] RECV_LAST  = 4'(RX_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    SHIFT,
    WAIT_RX,
    RECV,
    GAP
  } state_t;

  // A request is always two frames: address first, then data.
  function automatic logic [1:0] frame_cmd(input logic is_write, input logic second);
    logic [1:0] cmd;
    if (is_write) cmd = second ? CMD_WR_DATA : CMD_WR_ADDR;
    else          cmd = second ? CMD_RD_DATA : CMD_RD_ADDR;
    return cmd;
  endfunction

endpackage

// File: rtl/spi_master_shift.sv
// MOSI parallel-load shifter (MSB first) and MISO capture register,
// strobed by the controller FSM.
module spi_master_shift
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] load_word,
  input  logic                  shift,
  input  logic                  capture,
  input  logic                  miso,
  output logic                  mosi_bit,
  output logic [7:0]            rx_byte
);

  logic [FRAME_BITS-1:0] tx_reg;

  // Loading a new frame also discards any stale capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_reg  <= '0;
      rx_byte <= '0;
    end else begin
      if (load)       tx_reg <= load_word;
      else if (shift) tx_reg <= {tx_reg[FRAME_BITS-2:0], 1'b0};

      if (load)         rx_byte <= '0;
      else if (capture) rx_byte <= {rx_byte[6:0], miso};
    end
  end

  assign mosi_bit = tx_reg[FRAME_BITS-1];

endmodule

// File: rtl/spi_master_ctrl.sv
// Master-side sequencer: turns one write/read request into the two-frame
// SS_n/MOSI sequence for the SPI RAM slave and returns captured read data.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE  = 8,
  parameter int READ_WAIT  = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [7:0]           req_wdata,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  if (ADDR_SIZE != 8) begin : g_bad_addr_size
    $error("spi_master_ctrl: ADDR_SIZE must be 8");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("spi_master_ctrl: GAP_CYCLES must be at least 1");
  end

  localparam int WAIT_W = (READ_WAIT < 2) ? 1 : $clog2(READ_WAIT);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = (READ_WAIT > 0) ? WAIT_W'(READ_WAIT - 1) : '0;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES);

  state_t                 state;
  logic                   is_write;
  logic                   second;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [7:0]             wdata_q;
  logic [3:0]             bit_cnt;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [GAP_W-1:0]       gap_cnt;

  logic [1:0]             cur_cmd;
  logic [7:0]             payload;
  logic [FRAME_BITS-1:0]  load_word;
  logic                   rd_data_frame;
  logic                   mosi_bit;
  logic [7:0]             rx_byte;

  always_comb begin
    cur_cmd = frame_cmd(is_write, second);
    payload = addr_q;
    if (second) payload = is_write ? wdata_q : DUMMY_BYTE;
  end

  assign load_word     = {cur_cmd, payload};
  assign rd_data_frame = (cur_cmd == CMD_RD_DATA);
  assign req_ready     = (state == IDLE);

  spi_master_shift u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state == SEL),
    .load_word (load_word),
    .shift     (state == SHIFT),
    .capture   (state == RECV),
    .miso      (MISO),
    .mosi_bit  (mosi_bit),
    .rx_byte   (rx_byte)
  );

  // The first GAP edge closes the frame; the GAP state holds SS_n high
  // until the gap counter expires, then starts frame two or retires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      second    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          SS_n <= 1'b1;
          MOSI <= 1'b0;
          if (req_valid) begin
            is_write <= req_write;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            second   <= 1'b0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            gap_cnt  <= '0;
            busy     <= 1'b1;
            state    <= SEL;
          end
        end

        SEL: begin
          SS_n    <= 1'b0;
          MOSI    <= cur_cmd[1];
          bit_cnt <= '0;
          state   <= SHIFT;
        end

        SHIFT: begin
          MOSI <= mosi_bit;
          if (bit_cnt == SHIFT_LAST) begin
            bit_cnt <= '0;
            if (!rd_data_frame)  state <= GAP;
            else if (READ_WAIT == 0) state <= RECV;
            else                 state <= WAIT_RX;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        WAIT_RX: begin
          MOSI <= 1'b0;
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            state    <= RECV;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RECV: begin
          MOSI <= 1'b0;
          if (bit_cnt == RECV_LAST) begin
            bit_cnt <= '0;
            state   <= GAP;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        GAP: begin
          SS_n <= 1'b1;
          MOSI <= 1'b0;
          if (gap_cnt == '0 && rd_data_frame) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rx_byte;
          end
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            if (!second) begin
              second <= 1'b1;
              state  <= SEL;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: a behavioural SPI RAM slave decodes
// frames from MOSI and answers reads on MISO; expectations queue per request.
module tb_spi_master_ctrl;

  localparam int READ_WAIT  = 2;
  localparam int GAP_CYCLES = 1;
  localparam int WR_BUSY    = 26;
  localparam int RD_BUSY    = 36;
  localparam int WR_LOW     = 11;
  localparam int RD_LOW     = 21;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  spi_master_ctrl #(
    .ADDR_SIZE  (8),
    .READ_WAIT  (READ_WAIT),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] bits;
    int          len;
  } frame_t;

  frame_t     frame_q[$];
  logic [7:0] rsp_q[$];
  int         busy_q[$];

  logic [7:0] ref_mem   [256];
  logic [7:0] slave_mem [256];
  logic [7:0] slave_addr;
  logic [7:0] tx_byte;
  logic [10:0] rx_bits;

  int checks = 0;
  int errors = 0;
  int low_cnt = 0;
  bit in_frame = 0;
  int busy_run = 0;
  int frames_seen = 0;
  int rsp_seen = 0;
  int ready_busy_bad = 0;
  logic prev_rsp = 1'b0;
  int waited;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reset discards every in-flight expectation and any partial frame.
  always @(posedge clk) begin
    if (!rst_n) begin
      frame_q.delete();
      rsp_q.delete();
      busy_q.delete();
      low_cnt  = 0;
      in_frame = 0;
      busy_run = 0;
    end
  end

  // Slave model plus output monitors, all sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (req_ready !== !busy) ready_busy_bad++;

      if (SS_n === 1'b0) begin
        if (low_cnt < 11) rx_bits = {rx_bits[9:0], MOSI};
        low_cnt++;
        in_frame = 1;
        if (low_cnt == 11 && rx_bits[9:8] == 2'b11) tx_byte = slave_mem[slave_addr];
        if (low_cnt >= 13 && low_cnt <= 20) MISO = tx_byte[3'(20 - low_cnt)];
        else                                MISO = 1'($urandom);
      end else begin
        MISO = 1'($urandom);
        if (in_frame) begin
          frames_seen++;
          if (frame_q.size() == 0) begin
            checkOutput("frame_unexpected", frame_q.size(), 1);
          end else begin
            frame_t exp_f;
            exp_f = frame_q.pop_front();
            checkOutput("frame_bits", rx_bits, exp_f.bits);
            checkOutput("frame_len", low_cnt, exp_f.len);
          end
          if (low_cnt >= 11) begin
            case (rx_bits[9:8])
              2'b00, 2'b10: slave_addr = rx_bits[7:0];
              2'b01:        slave_mem[slave_addr] = rx_bits[7:0];
              default:      ;
            endcase
          end
          in_frame = 0;
          low_cnt  = 0;
        end
      end

      if (rsp_valid === 1'b1) begin
        rsp_seen++;
        checkOutput("rsp_single_pulse", prev_rsp, 0);
        if (rsp_q.size() == 0) checkOutput("rsp_unexpected", rsp_q.size(), 1);
        else                   checkOutput("rsp_rdata", rsp_rdata, rsp_q.pop_front());
      end
      prev_rsp = rsp_valid;

      if (busy === 1'b1) begin
        busy_run++;
      end else if (busy_run > 0) begin
        if (busy_q.size() == 0) checkOutput("busy_unexpected", busy_q.size(), 1);
        else                    checkOutput("busy_cycles", busy_run, busy_q.pop_front());
        busy_run = 0;
      end
    end
  end

  // Presents one request and queues everything it should produce once accepted.
  task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                               input logic [7:0] data, input bit hold,
                               output int wait_cycles);
    frame_t f;
    logic [1:0] c;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    req_valid = 1'b1;
    wait_cycles = 0;
    while (req_ready !== 1'b1 && wait_cycles < 200) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (req_ready !== 1'b1) begin
      checkOutput("accept_timeout", wait_cycles, 0);
      req_valid = 1'b0;
      return;
    end
    c = wr ? 2'b00 : 2'b10;
    f.bits = {c[1], c, addr};
    f.len  = WR_LOW;
    frame_q.push_back(f);
    c = wr ? 2'b01 : 2'b11;
    f.bits = {c[1], c, (wr ? data : 8'hFF)};
    f.len  = wr ? WR_LOW : RD_LOW;
    frame_q.push_back(f);
    if (wr) ref_mem[addr] = data;
    else    rsp_q.push_back(ref_mem[addr]);
    busy_q.push_back(wr ? WR_BUSY : RD_BUSY);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) checkOutput("idle_timeout", n, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = 8'h00;
      slave_mem[i] = 8'h00;
    end
    ref_mem[8'h33]   = 8'hA5;
    slave_mem[8'h33] = 8'hA5;
    slave_addr = 8'h00;
    tx_byte    = 8'h00;
    rx_bits    = '0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 8'h00;
    req_wdata  = 8'h00;
    MISO       = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ss_n", SS_n, 1);
    checkOutput("rst_mosi", MOSI, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_req_ready", req_ready, 1);

    applyStimulus(1'b1, 8'h50, 8'h90, 1'b0, waited);
    waitIdle();
    checkOutput("mem50_after_write", slave_mem[8'h50], 8'h90);

    applyStimulus(1'b0, 8'h50, 8'h00, 1'b0, waited);
    waitIdle();
    checkOutput("mem50_after_read", slave_mem[8'h50], 8'h90);

    applyStimulus(1'b0, 8'h33, 8'h00, 1'b0, waited);
    waitIdle();

    applyStimulus(1'b1, 8'h20, 8'h5A, 1'b1, waited);
    applyStimulus(1'b0, 8'h20, 8'h00, 1'b0, waited);
    checkOutput("b2b_accept_wait", waited, WR_BUSY);
    waitIdle();

    applyStimulus(1'b0, 8'h50, 8'h00, 1'b0, waited);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ss_n", SS_n, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_rsp_valid", rsp_valid, 0);
    checkOutput("midrst_rsp_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    applyStimulus(1'b1, 8'h10, 8'h3C, 1'b0, waited);
    waitIdle();
    checkOutput("mem10_after_write", slave_mem[8'h10], 8'h3C);

    applyStimulus(1'b0, 8'h10, 8'h00, 1'b0, waited);
    waitIdle();

    repeat (3) @(negedge clk);
    checkOutput("frame_q_drained", frame_q.size(), 0);
    checkOutput("rsp_q_drained", rsp_q.size(), 0);
    checkOutput("busy_q_drained", busy_q.size(), 0);
    checkOutput("frames_total", frames_seen, 14);
    checkOutput("rsp_total", rsp_seen, 4);
    checkOutput("ready_vs_busy", ready_busy_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
